syn_pipe_ctl: RTL and testbench

SYN_PIPE_CTL -- requirements
Module: syn_pipe_ctl

---
 rtl/syn_pipe_ctl_pkg.sv | 43 ++++
 rtl/syn_pipe_ctl_if.sv | 32 +++
 rtl/syn_pipe_ctl_cmb_hazard.sv | 28 ++
 rtl/syn_pipe_ctl.sv | 133 +++++++++++++
 tb/tb_syn_pipe_ctl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/syn_pipe_ctl_pkg.sv
// syn_pipe_ctl_pkg -- shared definitions for the pipeline controller.
//   Holds the controller state encoding, the hardwired zero register number,
//   the default statistics counter width, and the control-word type with the
//   named control words used by the output decode.
package syn_pipe_ctl_pkg;

  // Default width of every statistics counter.
  localparam int PCTL_CNT_W = 32;

  // Register number that is hardwired to zero and never creates a dependency.
  localparam logic [4:0] PCTL_ZERO_REG = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pctl_state_e;

  // Pipeline register control word driven by the controller.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_clr;
    logic exmem_en;
  } pctl_ctl_t;

  // Normal flow: everything advances.
  localparam pctl_ctl_t CTL_FLOW  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0,
                                      idex_clr: 1'b0, exmem_en: 1'b1};
  // Load-use stall: freeze PC and IF/ID, bubble into EX.
  localparam pctl_ctl_t CTL_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0,
                                      idex_clr: 1'b1, exmem_en: 1'b1};
  // Taken branch: load the target, squash the two younger slots.
  localparam pctl_ctl_t CTL_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b1,
                                      idex_clr: 1'b1, exmem_en: 1'b1};
  // Halt request: freeze the front end, let the syscall retire.
  localparam pctl_ctl_t CTL_HALT  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0,
                                      idex_clr: 1'b1, exmem_en: 1'b1};
  // Halted: nothing moves.
  localparam pctl_ctl_t CTL_IDLE  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0,
                                      idex_clr: 1'b0, exmem_en: 1'b0};

endpackage

// File: rtl/syn_pipe_ctl_if.sv
// syn_pipe_ctl_if -- pipeline status / control bundle between the datapath
// and the pipeline controller.
//   Status (datapath -> controller): id_rs, id_rt, id_use_rs, id_use_rt,
//     ex_mem_rd, ex_rd, ex_branched, ex_halt.
//   Control (controller -> datapath): pc_en, ifid_en, ifid_clr, idex_clr,
//     exmem_en.
//   modport master: datapath side; modport slave: controller side.
interface syn_pipe_ctl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_mem_rd;
  logic [4:0] ex_rd;
  logic       ex_branched;
  logic       ex_halt;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_clr;
  logic       idex_clr;
  logic       exmem_en;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_rd, ex_rd, ex_branched, ex_halt,
    input  pc_en, ifid_en, ifid_clr, idex_clr, exmem_en
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_rd, ex_rd, ex_branched, ex_halt,
    output pc_en, ifid_en, ifid_clr, idex_clr, exmem_en
  );
endinterface

// File: rtl/syn_pipe_ctl_cmb_hazard.sv
// cmb_hazard -- purely combinational load-use hazard detector.
//   Inputs : ex_mem_rd, ex_rd (EX-stage load and its destination),
//            id_rs, id_rt, id_use_rs, id_use_rt (ID-stage sources and usage).
//   Output : hazard, high when the ID instruction needs a value the EX load
//            has not produced yet.
module cmb_hazard
  import syn_pipe_ctl_pkg::*;
(
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       hazard
);

  logic rs_match_s;
  logic rt_match_s;

  // Only sources the instruction really reads may cause a stall.
  assign rs_match_s = id_use_rs & (id_rs == ex_rd);
  assign rt_match_s = id_use_rt & (id_rt == ex_rd);

  // Loads into the zero register never produce a usable value to wait for.
  assign hazard = ex_mem_rd & (ex_rd != PCTL_ZERO_REG) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/syn_pipe_ctl.sv
// syn_pipe_ctl -- pipeline controller: RUN/HALT FSM, pipeline register
// enable/clear decode and statistics counters.
//   clk, rst : single clock, asynchronous active-high reset.
//   go       : resume request, honoured only while halted.
//   bus      : status in / control out bundle (syn_pipe_ctl_if.slave).
//   halted   : registered, high while the core is halted.
//   cnt_cycle, cnt_taken, cnt_stall : registered wrapping counters of RUN
//              cycles, taken branches and load-use stalls.
module syn_pipe_ctl
  import syn_pipe_ctl_pkg::*;
#(
  parameter int CNT_W = PCTL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  syn_pipe_ctl_if.slave     bus,
  output logic              halted,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_stall
);

  pctl_state_e      state_r;
  pctl_state_e      state_next_s;
  pctl_ctl_t        ctl_s;
  logic             hazard_s;
  logic             halted_r;
  logic [CNT_W-1:0] cnt_cycle_r;
  logic [CNT_W-1:0] cnt_taken_r;
  logic [CNT_W-1:0] cnt_stall_r;

  cmb_hazard u_hazard (
    .ex_mem_rd (bus.ex_mem_rd),
    .ex_rd     (bus.ex_rd),
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .id_use_rs (bus.id_use_rs),
    .id_use_rt (bus.id_use_rt),
    .hazard    (hazard_s)
  );

  // State register; halted is registered from the next state so it tracks
  // the state exactly without a decode on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Next-state logic: halt wins over everything in RUN, go only matters in HALT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.ex_halt) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (go) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Output decode: in RUN the events are priority-ordered halt > branch > hazard.
  always_comb begin
    ctl_s = CTL_IDLE;
    case (state_r)
      ST_RUN: begin
        if (bus.ex_halt) begin
          ctl_s = CTL_HALT;
        end else if (bus.ex_branched) begin
          ctl_s = CTL_FLUSH;
        end else if (hazard_s) begin
          ctl_s = CTL_STALL;
        end else begin
          ctl_s = CTL_FLOW;
        end
      end
      ST_HALT: ctl_s = CTL_IDLE;
      default: ctl_s = CTL_IDLE;
    endcase
  end

  // Statistics counters; they advance only in RUN and wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_cycle_r <= '0;
      cnt_taken_r <= '0;
      cnt_stall_r <= '0;
    end else if (state_r == ST_RUN) begin
      cnt_cycle_r <= cnt_cycle_r + CNT_W'(1'b1);
      if (bus.ex_branched && !bus.ex_halt) begin
        cnt_taken_r <= cnt_taken_r + CNT_W'(1'b1);
      end else begin
        cnt_taken_r <= cnt_taken_r;
      end
      if (hazard_s && !bus.ex_branched && !bus.ex_halt) begin
        cnt_stall_r <= cnt_stall_r + CNT_W'(1'b1);
      end else begin
        cnt_stall_r <= cnt_stall_r;
      end
    end else begin
      cnt_cycle_r <= cnt_cycle_r;
      cnt_taken_r <= cnt_taken_r;
      cnt_stall_r <= cnt_stall_r;
    end
  end

  assign bus.pc_en    = ctl_s.pc_en;
  assign bus.ifid_en  = ctl_s.ifid_en;
  assign bus.ifid_clr = ctl_s.ifid_clr;
  assign bus.idex_clr = ctl_s.idex_clr;
  assign bus.exmem_en = ctl_s.exmem_en;

  assign halted    = halted_r;
  assign cnt_cycle = cnt_cycle_r;
  assign cnt_taken = cnt_taken_r;
  assign cnt_stall = cnt_stall_r;

endmodule

// File: tb/tb_syn_pipe_ctl.sv
// tb_syn_pipe_ctl -- self-checking bench for syn_pipe_ctl.
//   Two instances share the stimulus: the default 32-bit counter build and a
//   4-bit counter build that exercises wrap-around. Expected values come from
//   a cycle-level behavioural model of the controller kept in this file.
module tb_syn_pipe_ctl;

  logic       clk;
  logic       rst;
  logic       go;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_mem_rd;
  logic [4:0] ex_rd;
  logic       ex_branched;
  logic       ex_halt;

  logic        halted32;
  logic [31:0] cyc32, tak32, stl32;
  logic        halted4;
  logic [3:0]  cyc4, tak4, stl4;

  int tests;
  int fails;

  // Behavioural model state.
  bit          m_halted;
  int unsigned m_cyc;
  int unsigned m_tak;
  int unsigned m_stl;

  syn_pipe_ctl_if bus32 ();
  syn_pipe_ctl_if bus4 ();

  assign bus32.id_rs       = id_rs;
  assign bus32.id_rt       = id_rt;
  assign bus32.id_use_rs   = id_use_rs;
  assign bus32.id_use_rt   = id_use_rt;
  assign bus32.ex_mem_rd   = ex_mem_rd;
  assign bus32.ex_rd       = ex_rd;
  assign bus32.ex_branched = ex_branched;
  assign bus32.ex_halt     = ex_halt;
  assign bus4.id_rs        = id_rs;
  assign bus4.id_rt        = id_rt;
  assign bus4.id_use_rs    = id_use_rs;
  assign bus4.id_use_rt    = id_use_rt;
  assign bus4.ex_mem_rd    = ex_mem_rd;
  assign bus4.ex_rd        = ex_rd;
  assign bus4.ex_branched  = ex_branched;
  assign bus4.ex_halt      = ex_halt;

  syn_pipe_ctl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .go(go), .bus(bus32),
    .halted(halted32), .cnt_cycle(cyc32), .cnt_taken(tak32), .cnt_stall(stl32)
  );

  syn_pipe_ctl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .go(go), .bus(bus4),
    .halted(halted4), .cnt_cycle(cyc4), .cnt_taken(tak4), .cnt_stall(stl4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Does the ID instruction read a register the EX load is still producing?
  function automatic bit model_hazard();
    if (!ex_mem_rd || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
  endfunction

  // Expected {pc_en, ifid_en, ifid_clr, idex_clr, exmem_en}.
  function automatic logic [4:0] model_ctl();
    if (m_halted)    return 5'b00000;
    if (ex_halt)     return 5'b00011;
    if (ex_branched) return 5'b11111;
    if (model_hazard()) return 5'b00011;
    return 5'b11001;
  endfunction

  task automatic model_reset();
    m_halted = 1'b0;
    m_cyc = 0;
    m_tak = 0;
    m_stl = 0;
  endtask

  // One rising edge of the controller, described from the rules.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
      if (go) m_halted = 1'b0;
    end else begin
      m_cyc++;
      if (ex_halt) m_halted = 1'b1;
      else if (ex_branched) m_tak++;
      else if (model_hazard()) m_stl++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] exp_ctl;
    exp_ctl = model_ctl();
    chk({tag, ".ctl32"}, 32'({bus32.pc_en, bus32.ifid_en, bus32.ifid_clr, bus32.idex_clr, bus32.exmem_en}), 32'(exp_ctl));
    chk({tag, ".ctl4"},  32'({bus4.pc_en, bus4.ifid_en, bus4.ifid_clr, bus4.idex_clr, bus4.exmem_en}), 32'(exp_ctl));
    chk({tag, ".halted32"}, 32'(halted32), 32'(m_halted));
    chk({tag, ".halted4"},  32'(halted4),  32'(m_halted));
    chk({tag, ".cyc32"}, cyc32, m_cyc);
    chk({tag, ".tak32"}, tak32, m_tak);
    chk({tag, ".stl32"}, stl32, m_stl);
    chk({tag, ".cyc4"}, 32'(cyc4), 32'(m_cyc % 16));
    chk({tag, ".tak4"}, 32'(tak4), 32'(m_tak % 16));
    chk({tag, ".stl4"}, 32'(stl4), 32'(m_stl % 16));
  endtask

  // Inputs are set at the falling edge; check just after, then clock the model.
  task automatic cycle(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    go = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_mem_rd = 1'b0; ex_rd = 5'd0; ex_branched = 1'b0; ex_halt = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle_inputs();
    model_reset();

    // Reset state and RUN decode while reset is held.
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cycle("run_idle");

    // Load-use hazard on rs.
    ex_mem_rd = 1'b1; ex_rd = 5'd8; id_use_rs = 1'b1; id_rs = 5'd8;
    cycle("hazard_rs");
    idle_inputs();
    cycle("after_hazard");

    // Same pattern against the zero register: no stall.
    ex_mem_rd = 1'b1; ex_rd = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    cycle("hazard_r0");

    // Hazard on rt while rs is not read.
    ex_mem_rd = 1'b1; ex_rd = 5'd17; id_use_rs = 1'b0; id_rs = 5'd17;
    id_use_rt = 1'b1; id_rt = 5'd17;
    cycle("hazard_rt");

    // Branch masks a simultaneous hazard.
    ex_branched = 1'b1;
    cycle("branch_hazard");
    idle_inputs();

    // Halt with branch; go in RUN is ignored on the way.
    ex_halt = 1'b1; ex_branched = 1'b1; go = 1'b1;
    cycle("halt_branch");
    idle_inputs();

    // Ten halted cycles with events that must be ignored.
    for (int i = 0; i < 10; i++) begin
      ex_branched = 1'($urandom_range(0, 1));
      ex_halt = 1'($urandom_range(0, 1));
      ex_mem_rd = 1'b1; ex_rd = 5'd3; id_use_rs = 1'b1; id_rs = 5'd3;
      cycle("halted_idle");
    end
    idle_inputs();
    go = 1'b1;
    cycle("go_pulse");
    go = 1'b0;
    cycle("resumed");

    // Randomized traffic; small register range makes hazards frequent.
    for (int i = 0; i < 300; i++) begin
      go          = ($urandom_range(0, 3) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      ex_mem_rd   = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_branched = ($urandom_range(0, 4) == 0);
      ex_halt     = ($urandom_range(0, 11) == 0);
      cycle("random");
    end
    idle_inputs();

    // Asynchronous reset in HALT with counters at 5.
    rst = 1'b1;
    model_reset();
    cycle("pre_reset");
    rst = 1'b0;
    ex_branched = 1'b1;
    for (int i = 0; i < 4; i++) cycle("count_up");
    ex_branched = 1'b0; ex_halt = 1'b1;
    cycle("halt5");
    idle_inputs();
    cycle("halted5");
    chk("cyc_at_5", cyc32, 32'd5);
    #2;
    rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    chk("async_halted", 32'(halted32), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Seventeen RUN cycles wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) cycle("wrap");
    #1;
    chk("wrap_cyc4", 32'(cyc4), 32'd1);
    chk("wrap_cyc32", cyc32, 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
